dff: RTL and testbench
======================

# dff

Two-stage, enable-gated storage element: an internal storage register captures `d` on a read strobe, and a separate output register publishes the stored value to `q` on a write strobe. It serves as the basic latch-and-publish cell for register-file and port-buffer logic in the SoC, letting producers load a value ahead of time and expose it later with a distinct command. Both strobes are active-low, and all state changes on the rising clock edge.

## Interface
Parameters:
- `WIDTH`, 1: data width of `d`, storage and `q`.
- `RST_VAL`, `'0`: value loaded into storage and `q` on reset.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rstn`  input  1: reset, synchronous and active-low.
- `d`  input  WIDTH: data to capture.
- `re`  input  1: read enable, active-low; 0 captures `d` into storage.
- `we`  input  1: write enable, active-low; 0 drives storage onto `q`.
- `q`  output  WIDTH: registered output value.
- `vld`  output  1: storage has been loaded at least once since reset.

## Operation
- Two registers: `store` (WIDTH) and `q` (WIDTH), plus the 1-bit `vld` flag.
- Rising edge with `rstn`=0: `store`←RST_VAL, `q`←RST_VAL, `vld`←0. `re` and `we` are ignored.
- Rising edge with `rstn`=1:
  - `re`=0: `store`←`d`, `vld`←1.
  - `we`=0: `q`←`store`, using the pre-edge value of `store`.
  - `re`=1 / `we`=1: the corresponding register holds.
- `re`=0 and `we`=0 on the same edge: `q` takes the old `store`, and `store` takes `d`. No forwarding unless `DFF_BYPASS_EN` is defined.
- `q` is always driven: never tri-state, never X after reset.
- `d` changing while `re`=1 has no effect.

## Timing
- Load latency: `d` sampled at edge N is in `store` after edge N.
- Publish latency: `q` reflects `store` one edge after `we`=0 is sampled.
- Total latency from `d` to `q` is two edges: `re` at N, then `we` at N+1 or later.
- Reset takes effect at the first rising edge with `rstn`=0, not asynchronously. Before that edge, outputs are undefined.
- Reset asserted mid-operation overrides any pending `re`/`we` on that edge.
- All inputs are sampled only at the rising edge. Glitches between edges are irrelevant.

## Configuration
- Macro `DFF_BYPASS_EN`.
  - Defined: when `re`=0 and `we`=0 on the same edge, `q`←`d`, forwarding the new value. `store`←`d` as usual.
  - Undefined (default): `q`←old `store`, as specified in Operation.
- All other behaviour is identical in both builds.

## Structure
- Package `dff_pkg` holds:
  - default `WIDTH` constant (1),
  - default reset value constant (all zeros),
  - a `dff_data_t` typedef sized by the default width.
- One natural sub-module, `dff_reg`: a WIDTH-wide register with synchronous active-low reset, active-low enable, and parameterised reset value.
  - Instantiated twice: once as `store`, once as `q`.
  - `vld` is a small register in the top level.
- Bypass mux for `DFF_BYPASS_EN` sits in the top level, in front of the `q` instance's data input.

## Test plan
All scenarios use WIDTH=1 and RST_VAL=0.
- Reset: `rstn`=0, `re`=1, `we`=1, `d`=0 for 3 edges -> `q`=0, `vld`=0.
- Load only: `rstn`=1, `d`=1, `re`=0, `we`=1 for 2 edges, then `re`=1 -> `q` stays 0, `vld`=1.
- Publish: `we`=0 for 1+ edges -> `q`=1. Then `we`=1 -> `q` holds 1.
- Simultaneous: with `store`=1, set `re`=0, `we`=0, `d`=0 for one edge -> `q`=1, `store`=0. A further edge with `we`=0 -> `q`=0.
- Hold: `re`=1, `we`=1, toggle `d` 0/1 for 5 edges -> `q` and `store` unchanged.
- Reset mid-operation: `store`=1, `q`=1, assert `rstn`=0 with `re`=0, `we`=0, `d`=1 -> after the edge `q`=0, `store`=0, `vld`=0.
- With `DFF_BYPASS_EN` defined: repeat the simultaneous scenario -> `q`=0 immediately after the edge.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared defaults and types for the dff latch-and-publish cell.
package dff_pkg;

    localparam int DFF_WIDTH = 1;

    typedef logic [DFF_WIDTH-1:0] dff_data_t;

    localparam dff_data_t DFF_RST_VAL = '0;

endpackage

// File: rtl/dff_reg.sv
// WIDTH-wide register with synchronous active-low reset and active-low enable.
module dff_reg
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DFF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: reset is tested inside the clocked branch, not in the sensitivity list, so it acts only on a rising edge.
    // NOTE: non-blocking assignment lets a sibling register sample this one's pre-edge value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= RST_VAL;
        end else if (!en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff.sv
// Two-stage latch-and-publish cell: re (active-low) loads storage, we (active-low) publishes it to q.
// Define DFF_BYPASS_EN to forward d straight to q when re and we are both asserted on one edge.
module dff
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DFF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    input  logic             re,
    input  logic             we,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    logic [WIDTH-1:0] store;
    logic [WIDTH-1:0] q_din;

    dff_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) store_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (re),
        .d    (d),
        .q    (store)
    );

`ifdef DFF_BYPASS_EN
    // NOTE: continuous assign for the mux keeps it purely combinational, with no path to an inferred latch.
    assign q_din = (!re && !we) ? d : store;
`else
    assign q_din = store;
`endif

    dff_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) q_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (we),
        .d    (q_din),
        .q    (q)
    );

    // Sticky: once storage is loaded it stays valid until the next reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld <= 1'b0;
        end else if (!re) begin
            vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff (WIDTH=1, RST_VAL=0); expected state comes from a behavioural model.
module tb_dff;
    import dff_pkg::*;

`ifdef DFF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic q;
        logic vld;
        logic store;
    } exp_t;

    typedef struct {
        logic rstn;
        logic re;
        logic we;
        logic d;
    } stim_t;

    logic      clk = 1'b0;
    logic      rstn;
    dff_data_t d;
    logic      re;
    logic      we;
    dff_data_t q;
    logic      vld;

    logic m_store, m_q, m_vld;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .d    (d),
        .re   (re),
        .we   (we),
        .q    (q),
        .vld  (vld)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one edge worth of inputs, update the model, push the expected post-edge state.
    task automatic drive(input stim_t s);
        logic nq;
        exp_t e;
        @(negedge clk);
        rstn = s.rstn;
        re   = s.re;
        we   = s.we;
        d    = s.d;
        if (!s.rstn) begin
            m_store = 1'b0;
            m_q     = 1'b0;
            m_vld   = 1'b0;
        end else begin
            nq = m_q;
            if (!s.we) nq = (BYPASS && !s.re) ? s.d : m_store;
            if (!s.re) begin
                m_store = s.d;
                m_vld   = 1'b1;
            end
            m_q = nq;
        end
        e.q = m_q;
        e.vld = m_vld;
        e.store = m_store;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        s = '{rstn: 1'b0, re: 1'b1, we: 1'b1, d: 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(s);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL reset[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (vld !== e.vld)     begin errors++; $display("FAIL reset[%0d] vld: got %b expected %b", i, vld, e.vld); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL reset[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    task automatic test_load();
        stim_t seq[3];
        exp_t  e;
        seq[0] = '{rstn: 1'b1, re: 1'b0, we: 1'b1, d: 1'b1};
        seq[1] = '{rstn: 1'b1, re: 1'b0, we: 1'b1, d: 1'b1};
        seq[2] = '{rstn: 1'b1, re: 1'b1, we: 1'b1, d: 1'b0};
        foreach (seq[i]) begin
            drive(seq[i]);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL load[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (vld !== e.vld)     begin errors++; $display("FAIL load[%0d] vld: got %b expected %b", i, vld, e.vld); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL load[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    task automatic test_publish();
        stim_t seq[3];
        exp_t  e;
        seq[0] = '{rstn: 1'b1, re: 1'b1, we: 1'b0, d: 1'b0};
        seq[1] = '{rstn: 1'b1, re: 1'b1, we: 1'b0, d: 1'b0};
        seq[2] = '{rstn: 1'b1, re: 1'b1, we: 1'b1, d: 1'b0};
        foreach (seq[i]) begin
            drive(seq[i]);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL publish[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (vld !== e.vld)     begin errors++; $display("FAIL publish[%0d] vld: got %b expected %b", i, vld, e.vld); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL publish[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    // Entered with store=1; without bypass q takes the old store, with bypass it takes d.
    task automatic test_simultaneous();
        stim_t seq[2];
        exp_t  e;
        seq[0] = '{rstn: 1'b1, re: 1'b0, we: 1'b0, d: 1'b0};
        seq[1] = '{rstn: 1'b1, re: 1'b1, we: 1'b0, d: 1'b1};
        foreach (seq[i]) begin
            drive(seq[i]);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL simultaneous[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (vld !== e.vld)     begin errors++; $display("FAIL simultaneous[%0d] vld: got %b expected %b", i, vld, e.vld); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL simultaneous[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    task automatic test_hold();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 5; i++) begin
            s = '{rstn: 1'b1, re: 1'b1, we: 1'b1, d: logic'(i[0])};
            drive(s);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL hold[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL hold[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    task automatic test_reset_mid();
        stim_t seq[3];
        exp_t  e;
        seq[0] = '{rstn: 1'b1, re: 1'b0, we: 1'b1, d: 1'b1};
        seq[1] = '{rstn: 1'b1, re: 1'b1, we: 1'b0, d: 1'b0};
        seq[2] = '{rstn: 1'b0, re: 1'b0, we: 1'b0, d: 1'b1};
        foreach (seq[i]) begin
            drive(seq[i]);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL reset_mid[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (vld !== e.vld)     begin errors++; $display("FAIL reset_mid[%0d] vld: got %b expected %b", i, vld, e.vld); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL reset_mid[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 60; i++) begin
            s.rstn = ($urandom_range(0, 15) != 0);
            s.re   = logic'($urandom_range(0, 1));
            s.we   = logic'($urandom_range(0, 1));
            s.d    = logic'($urandom_range(0, 1));
            drive(s);
            e = sb.pop_front();
            checks++; if (q !== e.q)         begin errors++; $display("FAIL random[%0d] q: got %b expected %b", i, q, e.q); end
            checks++; if (vld !== e.vld)     begin errors++; $display("FAIL random[%0d] vld: got %b expected %b", i, vld, e.vld); end
            checks++; if (dut.store !== e.store) begin errors++; $display("FAIL random[%0d] store: got %b expected %b", i, dut.store, e.store); end
        end
    endtask

    initial begin
        rstn = 1'b1;
        re   = 1'b1;
        we   = 1'b1;
        d    = 1'b0;
        test_reset();
        test_load();
        test_publish();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
